// File: rtl/alu_pkg.sv
// Shared definitions for the tinygrad ALU serial ops: FSM encoding and sizing helpers.
package alu_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int DEF_WIDTH = 8;

  // Bit-counter width; floor of 1 keeps the declaration legal for tiny widths.
  function automatic int cnt_width(input int w);
    return (w > 1) ? $clog2(w) : 1;
  endfunction

endpackage

// File: rtl/full_subtractor_bit.sv
// One-bit full subtractor: d = a - b - bin, bout set when the bit borrows.
module full_subtractor_bit (
  input  logic a,
  input  logic b,
  input  logic bin,
  output logic d,
  output logic bout
);

  assign d    = a ^ b ^ bin;
  assign bout = (~a & b) | (~(a ^ b) & bin);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial a - b, LSB first, one bit per cycle; WIDTH+1-bit two's-complement result.
module serial_subtractor
  import alu_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH:0]   diff
);

  localparam int CW = cnt_width(WIDTH);

  state_t           state;
  logic [WIDTH-1:0] a_sr, b_sr;
  logic [WIDTH-2:0] res_sr;
  logic [WIDTH-2:0] res_shift;
  logic [CW-1:0]    cnt;
  logic             borrow;
  logic             d, bout;

  full_subtractor_bit u_fs (
    .a   (a_sr[0]),
    .b   (b_sr[0]),
    .bin (borrow),
    .d   (d),
    .bout(bout)
  );

  // Result bits enter at the top and drift down; the final bit never lands in res_sr.
  always_comb begin
    res_shift = (WIDTH-1)'({d, res_sr} >> 1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      diff      <= '0;
      cnt       <= '0;
      borrow    <= 1'b0;
      a_sr      <= '0;
      b_sr      <= '0;
      res_sr    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            a_sr     <= a;
            b_sr     <= b;
            res_sr   <= '0;
            cnt      <= '0;
            borrow   <= 1'b0;
            in_ready <= 1'b0;
            state    <= RUN;
          end
        end
        RUN: begin
          a_sr   <= a_sr >> 1;
          b_sr   <= b_sr >> 1;
          res_sr <= res_shift;
          borrow <= bout;
          cnt    <= cnt + 1'b1;
          if (cnt == CW'(WIDTH-1)) begin
            diff      <= {bout, d, res_sr};
            out_valid <= 1'b1;
            state     <= DONE;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= IDLE;
          end
        end
        default: begin
          out_valid <= 1'b0;
          in_ready  <= 1'b1;
          state     <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_subtractor.sv
// Directed-vector bench for serial_subtractor (WIDTH=8), expected values computed by hand.
module tb_serial_subtractor;

  localparam int WIDTH = 8;

  logic             clk = 1'b0;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a, b;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH:0]   diff;

  int n_vec = 0;
  int n_err = 0;

  serial_subtractor #(.WIDTH(WIDTH)) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .a        (a),
    .b        (b),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .diff     (diff)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance one clock; inputs are driven and outputs sampled 1 time unit after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_op(input string tag, input logic [7:0] va, input logic [7:0] vb,
                       input logic [8:0] exp);
    int lat;
    int w;
    w = 0;
    while (!in_ready && w < 20) begin step(); w++; end
    chk({tag, "_rdy"}, 32'(in_ready), 32'd1);
    a = va; b = vb; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 20) begin step(); lat++; end
    chk({tag, "_lat"}, 32'(lat), 32'd8);
    chk({tag, "_diff"}, 32'(diff), 32'(exp));
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    chk({tag, "_drain"}, 32'(out_valid), 32'd0);
  endtask

  initial begin
    logic [8:0] exp5 [3];
    logic [7:0] pa5 [3];
    logic [7:0] pb5 [3];
    int k, last_t, lat, cnt_ov;

    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; a = '0; b = '0;
    step(); step();
    rst = 1'b0;
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_diff", 32'(diff), 32'd0);

    // 1, 2: basic subtraction incl. negative results and full-range borrow
    do_op("t1_10_20", 8'd10, 8'd20, 9'h1F6);
    do_op("t2_255_1", 8'd255, 8'd1, 9'h0FE);
    do_op("t2_0_255", 8'd0, 8'd255, 9'h101);

    // 3: backpressure holds the result; in_valid pulses are ignored
    a = 8'd100; b = 8'd100; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 20) begin step(); lat++; end
    chk("t3_lat", 32'(lat), 32'd8);
    for (int i = 0; i < 5; i++) begin
      a = 8'(i * 37 + 1); b = 8'(i * 11); in_valid = (i % 2 == 0);
      step();
      chk("t3_hold_valid", 32'(out_valid), 32'd1);
      chk("t3_hold_diff", 32'(diff), 32'h000);
      chk("t3_hold_inrdy", 32'(in_ready), 32'd0);
    end
    in_valid = 1'b0; out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    chk("t3_release_inrdy", 32'(in_ready), 32'd1);
    cnt_ov = 0;
    for (int i = 0; i < 12; i++) begin step(); if (out_valid) cnt_ov++; end
    chk("t3_no_buffered", 32'(cnt_ov), 32'd0);

    // 4: reset in the 4th RUN cycle discards the operation
    a = 8'd200; b = 8'd3; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    step(); step(); step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("t4_in_ready", 32'(in_ready), 32'd1);
    chk("t4_out_valid", 32'(out_valid), 32'd0);
    chk("t4_diff", 32'(diff), 32'd0);
    cnt_ov = 0;
    for (int i = 0; i < 12; i++) begin step(); if (out_valid) cnt_ov++; end
    chk("t4_no_result", 32'(cnt_ov), 32'd0);
    do_op("t4_50_7", 8'd50, 8'd7, 9'h02B);

    // 5: back-to-back with in_valid and out_ready held high
    pa5[0] = 8'd1;   pb5[0] = 8'd2;   exp5[0] = 9'h1FF;
    pa5[1] = 8'd3;   pb5[1] = 8'd1;   exp5[1] = 9'h002;
    pa5[2] = 8'd128; pb5[2] = 8'd128; exp5[2] = 9'h000;
    k = 0; last_t = 0;
    a = pa5[0]; b = pb5[0]; in_valid = 1'b1; out_ready = 1'b1;
    for (int t = 1; t <= 60 && k < 3; t++) begin
      step();
      if (out_valid) begin
        chk("t5_diff", 32'(diff), 32'(exp5[k]));
        if (k > 0) chk("t5_spacing", 32'(t - last_t), 32'd10);
        last_t = t;
        k++;
        if (k < 3) begin a = pa5[k]; b = pb5[k]; end
        else in_valid = 1'b0;
      end
    end
    chk("t5_count", 32'(k), 32'd3);
    in_valid = 1'b0;
    step();
    out_ready = 1'b0;

    // 6: operand churn during RUN must not disturb the latched operands
    a = 8'd9; b = 8'd4; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 20) begin
      a = 8'($urandom); b = 8'($urandom);
      step(); lat++;
    end
    chk("t6_lat", 32'(lat), 32'd8);
    chk("t6_diff", 32'(diff), 32'h005);
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/serial_subtractor.md
Name: serial_subtractor

Overview:
Bit-serial two's-complement subtractor. It is the inverse-direction companion to the combinational adder in the tinygrad elementwise datapath and computes diff = a - b over WIDTH+1 bits. Operands are accepted on a valid/ready input handshake and processed LSB-first, one bit per cycle. The result is presented on a valid/ready output handshake. The block is the area-cheap SUB op for the tinygrad ALU path.

Parameters:
WIDTH, 8, operand width in bits (legal range WIDTH >= 2).

Ports:
clk  input  1  rising-edge clock, single clock domain
rst  input  1  synchronous reset, active-high
in_valid  input  1  operands a/b valid
in_ready  output  1  block can accept operands (high only in IDLE)
a  input  WIDTH  minuend, unsigned
b  input  WIDTH  subtrahend, unsigned
out_valid  output  1  diff valid (high only in DONE)
out_ready  input  1  consumer accepts diff
diff  output  WIDTH+1  a - b as a WIDTH+1-bit two's-complement value; MSB = final borrow = (a < b)

Behaviour:
- Reset (rst=1 at a clk edge): state=IDLE, out_valid=0, diff=0, bit counter=0, borrow=0, shift registers=0. Reset overrides every other input.
- Reset mid-operation: the in-flight operation is discarded and no result is ever emitted for it. The next cycle shows in_ready=1.
- FSM states:
  - IDLE: in_ready=1, out_valid=0. On in_valid=1: latch a and b into shift registers, counter=0, borrow=0, go to RUN. Otherwise stay.
  - RUN: in_ready=0, out_valid=0. Each edge computes one bit: d = a_i ^ b_i ^ bin; bout = (~a_i & b_i) | (~(a_i ^ b_i) & bin). Shift d into the result register LSB-first and increment the counter. At the edge where counter == WIDTH-1, load diff = {bout, result bits}, then go to DONE.
  - DONE: out_valid=1, in_ready=0, diff stable. On out_ready=1: go to IDLE. Otherwise hold.
- Latency: out_valid rises exactly WIDTH cycles after the accepting edge. Throughput is one result per WIDTH+2 cycles with out_ready held high.
- a and b are sampled only at the accepting edge. Changes to them during RUN or DONE have no effect.
- in_valid during RUN or DONE is ignored and is not buffered.
- diff updates only on entry to DONE. It holds its last value through IDLE until the next result replaces it.
- Arithmetic: diff = (a - b) mod 2^(WIDTH+1), i.e. exact signed a-b. No saturation. Wrap-around is fully covered by the WIDTH+1 result width.
- Unused state encoding: returns to IDLE on the next edge.

Decomposition:
- Shared package (alu_pkg):
  - state encoding constants IDLE=2'd0, RUN=2'd1, DONE=2'd2
  - default WIDTH=8
  - counter width = clog2(WIDTH)
- Natural sub-module: full_subtractor_bit. It is combinational, with inputs a, b, bin and outputs d, bout, and is instantiated once in the RUN datapath.

Test Plan:
1. a=10, b=20 after reset -> out_valid exactly 8 cycles after accept, diff=9'h1F6 (-10).
2. a=255, b=1 -> diff=9'h0FE. Then a=0, b=255 -> diff=9'h101 (-255, borrow=1).
3. a=100, b=100 -> diff=9'h000. out_ready held 0 for 5 cycles -> out_valid=1, diff constant, in_ready=0, and a new in_valid pulse is ignored throughout.
4. rst pulsed during the 4th RUN cycle of a=200, b=3 -> next cycle in_ready=1, out_valid=0, diff=0, and no result emitted. Then a=50, b=7 -> diff=9'h02B (43).
5. in_valid and out_ready held high with operand pairs (1,2), (3,1), (128,128) -> results 9'h1FF, 9'h002, 9'h000 in order, one every 10 cycles.
6. Operands changed every cycle during RUN after accepting a=9, b=4 -> diff=9'h005.
